// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between a CPU and an IO requester.
// The CPU owns the memory by default; an IO request stalls the CPU (cpu_en=0) while
// IO owns the bus, followed by a one-cycle TAIL that re-presents the stalled CPU
// address so the CPU sees correct read data when it resumes.
// Optional feature macro: MEM_ARB_BURST_LIMIT_EN bounds an IO ownership to MAXBURST
// cycles. Without it IO keeps the memory for as long as io_req stays high.
module mem_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAXBURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_writedata,
    input  logic             cpu_memwrite,
    output logic [WIDTH-1:0] cpu_memdata,
    output logic             cpu_en,
    input  logic             io_req,
    input  logic             io_we,
    input  logic [WIDTH-1:0] io_adr,
    input  logic [WIDTH-1:0] io_wdata,
    output logic             io_gnt,
    output logic [WIDTH-1:0] io_rdata,
    output logic             io_rvalid,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_IO   = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       mem_we_raw;
    logic       burst_done;
    logic       io_rvalid_reg;
    logic [WIDTH-1:0] rdata_hold_reg;

    // The burst counter is 4 bits wide, so MAXBURST must stay within 1..15.
    if (MAXBURST < 1 || MAXBURST > 15) begin : g_maxburst_range
        $error("mem_arbiter: MAXBURST must be in 1..15");
    end

`ifdef MEM_ARB_BURST_LIMIT_EN
    logic [3:0] burst_cnt_reg;

    // IO is only ever entered from CPU, so clearing during every CPU cycle
    // is the same as clearing on IO entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt_reg <= 4'd0;
        end else if (state_reg == ST_CPU) begin
            burst_cnt_reg <= 4'd0;
        end else if (state_reg == ST_IO) begin
            burst_cnt_reg <= burst_cnt_reg + 4'd1;
        end
    end

    // Last permitted IO cycle of this ownership.
    assign burst_done = (burst_cnt_reg == 4'(MAXBURST - 1));
`else
    // No burst limit: IO ownership lasts as long as io_req stays high.
    assign burst_done = 1'b0;
`endif

    // State register; reset aborts any IO ownership immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_CPU;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and memory-bus steering.
    always_comb begin
        state_next = state_reg;
        mem_adr    = cpu_adr;
        mem_wdata  = cpu_writedata;
        mem_we_raw = 1'b0;
        cpu_en     = 1'b0;
        io_gnt     = 1'b0;
        case (state_reg)
            ST_CPU: begin
                mem_we_raw = cpu_memwrite;
                cpu_en     = 1'b1;
                state_next = io_req ? ST_IO : ST_CPU;
            end
            ST_IO: begin
                mem_adr    = io_adr;
                mem_wdata  = io_wdata;
                mem_we_raw = io_req & io_we;
                io_gnt     = 1'b1;
                state_next = (!io_req || burst_done) ? ST_TAIL : ST_IO;
            end
            ST_TAIL: begin
                // Re-present the stalled CPU address so read data is valid on resume.
                state_next = ST_CPU;
            end
            default: begin
                state_next = ST_CPU;
            end
        endcase
    end

    // Writes are suppressed for as long as reset is held.
    assign mem_we = mem_we_raw & reset;

    // Flag an IO read completing at this edge; its data arrives next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_rvalid_reg <= 1'b0;
        end else begin
            io_rvalid_reg <= (state_reg == ST_IO) && io_req && !io_we;
        end
    end

    // Keep the last IO read word so io_rdata stays stable between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_hold_reg <= '0;
        end else if (io_rvalid_reg) begin
            rdata_hold_reg <= mem_rdata;
        end
    end

    // mem_rdata is the memory's own registered output, so it is forwarded directly
    // during the valid cycle.
    assign io_rdata    = io_rvalid_reg ? mem_rdata : rdata_hold_reg;
    assign io_rvalid   = io_rvalid_reg;
    assign cpu_memdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a synchronous memory model.
// Expected io_gnt / cpu_en patterns depend on MEM_ARB_BURST_LIMIT_EN.
module tb_mem_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAXBURST = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] cpu_adr;
    logic [WIDTH-1:0] cpu_writedata;
    logic             cpu_memwrite;
    logic [WIDTH-1:0] cpu_memdata;
    logic             cpu_en;
    logic             io_req;
    logic             io_we;
    logic [WIDTH-1:0] io_adr;
    logic [WIDTH-1:0] io_wdata;
    logic             io_gnt;
    logic [WIDTH-1:0] io_rdata;
    logic             io_rvalid;
    logic [WIDTH-1:0] mem_adr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    logic [WIDTH-1:0] mem_array [0:255];

    int tests_run    = 0;
    int tests_failed = 0;

    mem_arbiter #(.WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_adr       (cpu_adr),
        .cpu_writedata (cpu_writedata),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_memdata   (cpu_memdata),
        .cpu_en        (cpu_en),
        .io_req        (io_req),
        .io_we         (io_we),
        .io_adr        (io_adr),
        .io_wdata      (io_wdata),
        .io_gnt        (io_gnt),
        .io_rdata      (io_rdata),
        .io_rvalid     (io_rvalid),
        .mem_adr       (mem_adr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read-before-write, data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem_array[mem_adr] <= mem_wdata;
        mem_rdata <= mem_array[mem_adr];
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [13:0] gnt_pat;
    logic [13:0] en_pat;
    logic [13:0] exp_gnt_pat;
    logic [13:0] exp_en_pat;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        reset         = 1'b0;
        cpu_adr       = 8'h44;
        cpu_writedata = 8'h99;
        cpu_memwrite  = 1'b1;
        io_req        = 1'b0;
        io_we         = 1'b0;
        io_adr        = 8'h00;
        io_wdata      = 8'h00;
        #2;
        check_value("rst_cpu_en",    32'(cpu_en),    32'h1);
        check_value("rst_io_gnt",    32'(io_gnt),    32'h0);
        check_value("rst_mem_we",    32'(mem_we),    32'h0);
        check_value("rst_mem_adr",   32'(mem_adr),   32'h44);
        check_value("rst_mem_wdata", 32'(mem_wdata), 32'h99);
        check_value("rst_io_rvalid", 32'(io_rvalid), 32'h0);
        check_value("rst_io_rdata",  32'(io_rdata),  32'h0);
        tick();
        tick();
        reset        = 1'b1;
        cpu_memwrite = 1'b0;

        // ---------------- CPU write then read, no IO ----------------
        cpu_adr = 8'h10; cpu_writedata = 8'h5A; cpu_memwrite = 1'b1;
        #1;
        check_value("cpuwr_mem_we",  32'(mem_we),    32'h1);
        check_value("cpuwr_mem_adr", 32'(mem_adr),   32'h10);
        check_value("cpuwr_wdata",   32'(mem_wdata), 32'h5A);
        check_value("cpuwr_cpu_en",  32'(cpu_en),    32'h1);
        tick();
        cpu_memwrite = 1'b0;
        #1;
        check_value("cpurd_mem_we",  32'(mem_we), 32'h0);
        check_value("cpurd_cpu_en",  32'(cpu_en), 32'h1);
        tick();
        check_value("cpurd_data",    32'(cpu_memdata), 32'h5A);
        check_value("cpurd_cpu_en2", 32'(cpu_en),      32'h1);

        // ---------------- IO single read ----------------
        cpu_adr = 8'h20; cpu_writedata = 8'hC3; cpu_memwrite = 1'b1;
        tick();
        cpu_memwrite = 1'b0; cpu_adr = 8'h50;
        io_req = 1'b1; io_we = 1'b0; io_adr = 8'h20;
        #1;
        check_value("iord_req_gnt",    32'(io_gnt), 32'h0);
        check_value("iord_req_cpu_en", 32'(cpu_en), 32'h1);
        tick();
        check_value("iord_gnt",      32'(io_gnt),    32'h1);
        check_value("iord_cpu_en",   32'(cpu_en),    32'h0);
        check_value("iord_mem_adr",  32'(mem_adr),   32'h20);
        check_value("iord_mem_we",   32'(mem_we),    32'h0);
        check_value("iord_rvalid0",  32'(io_rvalid), 32'h0);
        tick();
        io_req = 1'b0;
        #1;
        check_value("iord_rvalid",   32'(io_rvalid), 32'h1);
        check_value("iord_rdata",    32'(io_rdata),  32'hC3);
        check_value("iord_gnt_drop", 32'(io_gnt),    32'h1);
        check_value("iord_nowr",     32'(mem_we),    32'h0);
        tick();
        check_value("tail_gnt",      32'(io_gnt),    32'h0);
        check_value("tail_cpu_en",   32'(cpu_en),    32'h0);
        check_value("tail_mem_adr",  32'(mem_adr),   32'h50);
        check_value("tail_mem_we",   32'(mem_we),    32'h0);
        check_value("tail_rvalid",   32'(io_rvalid), 32'h0);
        tick();
        check_value("resume_cpu_en", 32'(cpu_en),    32'h1);

        // ---------------- IO write burst ----------------
        cpu_adr = 8'h10;
        io_req = 1'b1; io_we = 1'b1; io_adr = 8'h30; io_wdata = 8'h01;
        #1;
        check_value("iowr_cpu_cycle_we", 32'(mem_we), 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            io_adr   = 8'(8'h30 + k);
            io_wdata = 8'(k + 1);
            #1;
            check_value($sformatf("iowr%0d_we", k),    32'(mem_we),    32'h1);
            check_value($sformatf("iowr%0d_adr", k),   32'(mem_adr),   32'(8'h30 + k));
            check_value($sformatf("iowr%0d_data", k),  32'(mem_wdata), 32'(k + 1));
            check_value($sformatf("iowr%0d_cpu_en", k), 32'(cpu_en),   32'h0);
            tick();
        end
        io_req = 1'b0;
        #1;
        check_value("iowr_end_gnt", 32'(io_gnt), 32'h1);
        check_value("iowr_end_we",  32'(mem_we), 32'h0);
        tick();
        check_value("iowr_tail_adr",    32'(mem_adr), 32'h10);
        check_value("iowr_tail_cpu_en", 32'(cpu_en),  32'h0);
        tick();
        check_value("iowr_resume_en",   32'(cpu_en),      32'h1);
        check_value("iowr_resume_data", 32'(cpu_memdata), 32'h5A);
        check_value("iowr_mem30", 32'(mem_array[8'h30]), 32'h01);
        check_value("iowr_mem31", 32'(mem_array[8'h31]), 32'h02);
        check_value("iowr_mem32", 32'(mem_array[8'h32]), 32'h03);

        // ---------------- CPU write and IO request in the same cycle ----------------
        cpu_adr = 8'h60; cpu_writedata = 8'h77; cpu_memwrite = 1'b1;
        io_req = 1'b1; io_we = 1'b0; io_adr = 8'h60;
        #1;
        check_value("coll_mem_we", 32'(mem_we), 32'h1);
        check_value("coll_gnt0",   32'(io_gnt), 32'h0);
        tick();
        cpu_memwrite = 1'b0;
        #1;
        check_value("coll_gnt1",   32'(io_gnt),            32'h1);
        check_value("coll_mem60",  32'(mem_array[8'h60]),  32'h77);
        tick();
        io_req = 1'b0;
        #1;
        check_value("coll_rvalid", 32'(io_rvalid), 32'h1);
        check_value("coll_rdata",  32'(io_rdata),  32'h77);
        tick();
        tick();
        check_value("coll_resume", 32'(cpu_en), 32'h1);

        // ---------------- io_req held 10 cycles ----------------
        io_we = 1'b0; io_adr = 8'h20;
        for (int c = 0; c < 14; c++) begin
            io_req = (c < 10);
            #1;
            gnt_pat[c] = io_gnt;
            en_pat[c]  = cpu_en;
            tick();
        end
`ifdef MEM_ARB_BURST_LIMIT_EN
        exp_gnt_pat = 14'h079E;
        exp_en_pat  = 14'h3041;
`else
        exp_gnt_pat = 14'h07FE;
        exp_en_pat  = 14'h3001;
`endif
        check_value("hold10_gnt_pattern",    32'(gnt_pat), 32'(exp_gnt_pat));
        check_value("hold10_cpu_en_pattern", 32'(en_pat),  32'(exp_en_pat));

        // ---------------- reset during an IO read burst ----------------
        io_req = 1'b1; io_we = 1'b0; io_adr = 8'h20;
        tick();
        tick();
        check_value("rstio_pre_gnt",    32'(io_gnt),    32'h1);
        check_value("rstio_pre_rvalid", 32'(io_rvalid), 32'h1);
        reset = 1'b0;
        #1;
        check_value("rstio_gnt",    32'(io_gnt),    32'h0);
        check_value("rstio_mem_we", 32'(mem_we),    32'h0);
        check_value("rstio_rvalid", 32'(io_rvalid), 32'h0);
        check_value("rstio_cpu_en", 32'(cpu_en),    32'h1);
        check_value("rstio_rdata",  32'(io_rdata),  32'h0);
        tick();
        reset = 1'b1;
        #1;
        check_value("rel_cpu_en", 32'(cpu_en),    32'h1);
        check_value("rel_gnt",    32'(io_gnt),    32'h0);
        tick();
        check_value("rel_rvalid", 32'(io_rvalid), 32'h0);
        check_value("rel_gnt2",   32'(io_gnt),    32'h1);
        io_req = 1'b0;
        tick();
        tick();
        check_value("rel_resume", 32'(cpu_en), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
